// File: rtl/ram_sdp_be.sv
// Simple-dual-port RAM with a byte-enabled write port, a registered read port
// with a valid flag, a selectable read-during-write policy and a clear engine
// that zeroes the whole array after reset or on request.
//
//   state | meaning
//   ------+---------------------------------------------------------------
//   CLEAR | clear engine writes zero to array[ptr] each edge; ports ignored
//   IDLE  | normal operation; write and read ports active, clr accepted
module ram_sdp_be #(
   parameter int Data_width = 32,
   parameter int Addr_width = 7,
   parameter int Byte_width = 8,
   parameter int RDW_mode   = 0
) (
   input  logic                               clk,
   input  logic                               rst,
   input  logic                               clr,
   output logic                               busy,
   input  logic                               we,
   input  logic [Addr_width-1:0]              waddr,
   input  logic [Data_width/Byte_width-1:0]   be,
   input  logic [Data_width-1:0]              d,
   input  logic                               re,
   input  logic [Addr_width-1:0]              raddr,
   output logic [Data_width-1:0]              q,
   output logic                               q_valid
);

   localparam int Lanes = Data_width / Byte_width;

   typedef enum logic {CLEAR, IDLE} state_t;

   state_t                state;
   logic [Addr_width-1:0] ptr;
   logic [Data_width-1:0] mem [2**Addr_width];
   logic                  accept_wr;
   logic                  accept_rd;
   logic [Data_width-1:0] rd_word;

   // A clr in IDLE takes priority over any port access in the same cycle.
   assign accept_wr = (state == IDLE) && !clr && we;
   assign accept_rd = (state == IDLE) && !clr && re;
   assign busy      = (state == CLEAR);

   // Clear sequencing: sweep the pointer over every address, then go idle.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state <= CLEAR;
         ptr   <= '0;
      end else begin
         case (state)
            CLEAR: begin
               ptr <= ptr + 1'b1;
               if (ptr == '1) state <= IDLE;
            end
            IDLE: begin
               if (clr) begin
                  state <= CLEAR;
                  ptr   <= '0;
               end
            end
            default: begin
               state <= CLEAR;
               ptr   <= '0;
            end
         endcase
      end
   end

   // Read data selection; in new-data mode enabled lanes of a colliding write bypass the array.
   always_comb begin
      rd_word = mem[raddr];
      if ((RDW_mode != 0) && accept_wr && (waddr == raddr)) begin
         for (int i = 0; i < Lanes; i++) begin
            if (be[i]) rd_word[i*Byte_width +: Byte_width] = d[i*Byte_width +: Byte_width];
         end
      end
   end

   // Array update: zero fill while clearing, byte-lane merge write when idle.
   always_ff @(posedge clk) begin
      if (state == CLEAR) begin
         mem[ptr] <= '0;
      end else if (accept_wr) begin
         for (int i = 0; i < Lanes; i++) begin
            if (be[i]) mem[waddr][i*Byte_width +: Byte_width] <= d[i*Byte_width +: Byte_width];
         end
      end
   end

   // Registered read port; q holds its value whenever no read is accepted.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         q       <= '0;
         q_valid <= 1'b0;
      end else if (accept_rd) begin
         q       <= rd_word;
         q_valid <= 1'b1;
      end else begin
         q_valid <= 1'b0;
      end
   end

endmodule
